fetch_prefetch_queue: RTL



---
 rtl/fetch_prefetch_queue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// Prefetch queue: sequential fetches over req/gnt/rvalid into a {pc,instr} FIFO for decode; PFQ_PERF_CNT_EN adds discard/issue counters.
// Latency grant->instr_valid is 2 cycles; StallF holds the head; fetch issue is reserved so a response never finds the queue full.
module fetch_prefetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrcE,
    input  logic [31:0] PCTarget,
    input  logic        StallF,
    output logic        instr_valid,
    output logic [31:0] InstrF,
    output logic [31:0] pcF,
    output logic [31:0] PCPlus4F
`ifdef PFQ_PERF_CNT_EN
    ,
    output logic [15:0] discard_cnt,
    output logic [31:0] issue_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]                fpc_q, fpc_d;
    logic [AW-1:0]              head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;
    logic [31:0]                q_pc    [DEPTH];
    logic [31:0]                q_instr [DEPTH];

    logic [TW-1:0]              trd_q, trd_d, twr_q, twr_d;
    logic [OW-1:0]              out_q, out_d;
    logic [MAX_OUTSTANDING-1:0] kill_q, kill_d;
    logic [31:0]                t_pc    [MAX_OUTSTANDING];

    logic        issue, trk_pop, push, pop;
    logic [31:0] occupancy;

    function automatic logic [TW-1:0] tinc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Queue slots are reserved at grant time, so in-flight fetches count against DEPTH.
    assign occupancy = 32'(count_q) + 32'(out_q);
    assign imem_req  = !reset && !PCSrcE && (occupancy < 32'(DEPTH))
                       && (32'(out_q) < 32'(MAX_OUTSTANDING));
    assign imem_addr = fpc_q;

    assign issue   = imem_req && imem_gnt;
    assign trk_pop = imem_rvalid && (out_q != '0);
    assign push    = trk_pop && !kill_q[trd_q] && !PCSrcE;

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && !StallF;
    assign InstrF      = instr_valid ? q_instr[head_q] : NOP;
    assign pcF         = instr_valid ? q_pc[head_q]    : 32'd0;
    assign PCPlus4F    = pcF + 32'd4;

    always_comb begin
        fpc_d   = fpc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        trd_d   = trd_q;
        twr_d   = twr_q;
        out_d   = out_q;
        kill_d  = kill_q;

        if (PCSrcE)     fpc_d = {PCTarget[31:2], 2'b00};
        else if (issue) fpc_d = fpc_q + 32'd4;

        if (issue) begin
            twr_d         = tinc(twr_q);
            kill_d[twr_q] = 1'b0;
        end
        if (trk_pop) trd_d = tinc(trd_q);
        case ({issue, trk_pop})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase

        // A redirect poisons every in-flight fetch; their responses still drain the tracker.
        if (PCSrcE) begin
            kill_d  = '1;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q   <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            trd_q   <= '0;
            twr_q   <= '0;
            out_q   <= '0;
            kill_q  <= '0;
        end else begin
            fpc_q   <= fpc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            trd_q   <= trd_d;
            twr_q   <= twr_d;
            out_q   <= out_d;
            kill_q  <= kill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) t_pc[twr_q] <= fpc_q;
        if (push) begin
            q_pc[tail_q]    <= t_pc[trd_q];
            q_instr[tail_q] <= imem_rdata;
        end
    end

`ifdef PFQ_PERF_CNT_EN
    logic [15:0] discard_cnt_q;
    logic [31:0] issue_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            discard_cnt_q <= '0;
            issue_cnt_q   <= '0;
        end else begin
            if (trk_pop && !push && (discard_cnt_q != 16'hFFFF))
                discard_cnt_q <= discard_cnt_q + 16'd1;
            if (issue)
                issue_cnt_q <= issue_cnt_q + 32'd1;
        end
    end

    assign discard_cnt = discard_cnt_q;
    assign issue_cnt   = issue_cnt_q;
`endif
endmodule
